if_id_queue: RTL
================

Name: if_id_queue

Overview:
- Elastic instruction queue between the fetch stage (ifetch) and the decode/register-read stage of the CPU.
- Buffers fetched {instruction, PC+4} pairs in a small circular FIFO with valid/ready handshakes on both sides.
- Fetch uses in_ready as its write_pc enable, so a full queue stalls the PC.
- Pre-splits the head instruction into MIPS fields for decode.
- A flush, driven by a taken branch or jump, discards all wrong-path entries.

Parameters:
DEPTH, 2, number of entries; power of two, >= 2
PTR_W, 1, pointer width = log2(DEPTH); set consistently with DEPTH

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  fetch presents a valid instruction
in_instr  input  32  instruction word from fetch (ifetch out)
in_pc4  input  32  PC+4 of that instruction (ifetch increased_pc)
in_ready  output  1  queue can accept; drives fetch write_pc
flush  input  1  discard all entries (taken branch/jump resolved)
out_valid  output  1  head entry valid
out_ready  input  1  decode consumes head this cycle
out_instr  output  32  head instruction
out_pc4  output  32  head PC+4
out_opcode  output  6  head [31:26]
out_rs  output  5  head [25:21]
out_rt  output  5  head [20:16]
out_rd  output  5  head [15:11]
out_shamt  output  5  head [10:6]
out_funct  output  6  head [5:0]
out_imm_sext  output  32  head [15:0] sign-extended
out_jtarget  output  26  head [25:0]
level  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr = 0, rd_ptr = 0, count = 0; all storage cleared to 0.
  - in_ready = 0 while rst_n is low; in_ready = 1 from the first cycle after release.
  - out_valid = 0, level = 0, all out_* fields = 0.
- Occupancy signals:
  - in_ready = rst_n & (count < DEPTH).
  - in_ready is independent of out_ready; there is no pass-through when full.
  - out_valid = (count != 0). level = count.
- Push: in_valid & in_ready & !flush.
  - Writes {in_instr, in_pc4} at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: out_valid & out_ready & !flush.
  - rd_ptr increments modulo DEPTH.
- Push and pop in the same cycle: count unchanged, both pointers advance. This is legal when count = DEPTH only if the pop does not enable the push; in_ready stays 0.
- Push only: count+1. Pop only: count-1.
- Flush has priority over push and pop in the same cycle.
  - Next cycle: count = 0, wr_ptr = rd_ptr = 0.
  - Storage contents need not be cleared.
  - The in_valid word presented in the flush cycle is dropped.
- Latency: an entry pushed at edge N is visible on out_* after edge N (out_valid = 1 in cycle N+1). Minimum fall-through is one cycle; there is no combinational in-to-out path.
- Head outputs:
  - Combinational from the entry at rd_ptr, masked to all-zero when out_valid = 0. A zero instruction is the MIPS NOP (sll $0,$0,0).
  - out_imm_sext = {{16{instr[15]}}, instr[15:0]}.
- Stability rule: while out_valid = 1 and out_ready = 0, all out_* hold stable until popped or flushed.
- Upstream contract: in_instr and in_pc4 are sampled only on push; values while !in_ready are ignored.
- Pointer wrap: at DEPTH-1 the pointer returns to 0. Full and empty are distinguished by count, never by pointer equality.
- Reset mid-operation: all entries are lost immediately; no partial state survives.

Test Plan:
- Reset, then push instr 0x8C080004 / pc4 0x00000004 with out_ready=0 -> next cycle out_valid=1, level=1, out_opcode=0x23, out_rs=0, out_rt=8, out_imm_sext=0x00000004.
- Push 0x11090003 and 0x08000007 (pc4 4, 8) with out_ready=0 -> level=2, in_ready=0; a third in_valid word is not accepted. Raise out_ready for 2 cycles -> outputs 0x11090003 then 0x08000007 in order; out_jtarget=0x0000007 on the second.
- Steady stream with in_valid=out_ready=1 for 8 cycles, pc4 4,8,...,32 -> level stays 1 after fill. Each pc4 is delivered exactly once, in order, across pointer wrap.
- Branch offset 0xFFFC (instr 0x1000FFFC) at head -> out_imm_sext=0xFFFFFFFC.
- Queue full (level=2), assert flush with in_valid=1 and out_ready=1 -> next cycle level=0, out_valid=0, out_instr=0, in_ready=1. The flush-cycle word never appears.
- Drop rst_n asynchronously mid-stream between clock edges, with level=1 -> out_valid and level go to 0 immediately. in_ready=0 until release, then 1.

Source files
------------

// File: rtl/if_id_queue_if.sv
// if_id_queue_if: fetch-to-decode handshake bundle for the if/id instruction queue.
interface if_id_queue_if #(parameter int PTR_W = 1);
  logic              in_valid;
  logic [31:0]       in_instr;
  logic [31:0]       in_pc4;
  logic              in_ready;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc4;
  logic [5:0]        out_opcode;
  logic [4:0]        out_rs;
  logic [4:0]        out_rt;
  logic [4:0]        out_rd;
  logic [4:0]        out_shamt;
  logic [5:0]        out_funct;
  logic [31:0]       out_imm_sext;
  logic [25:0]       out_jtarget;
  logic [PTR_W:0]    level;
  modport master (
    output in_valid, in_instr, in_pc4, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc4, out_opcode, out_rs, out_rt,
           out_rd, out_shamt, out_funct, out_imm_sext, out_jtarget, level
  );
  modport slave (
    input  in_valid, in_instr, in_pc4, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc4, out_opcode, out_rs, out_rt,
           out_rd, out_shamt, out_funct, out_imm_sext, out_jtarget, level
  );
endinterface

// File: rtl/if_id_queue.sv
// if_id_queue: elastic circular FIFO of {instr, pc4} between fetch and decode.
// Head instruction is pre-split into MIPS fields; flush drops all wrong-path entries.
module if_id_queue #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input logic         clk,
  input logic         rst_n,
  if_id_queue_if.slave bus
);
  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      instr_d [DEPTH];
  logic [31:0]      pc4_q [DEPTH];
  logic [31:0]      pc4_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;
  logic [31:0]      head;
  always_comb begin
    bus.in_ready = rst_n && (count_q < (PTR_W+1)'(DEPTH));
    bus.out_valid = count_q != '0;
    bus.level = count_q;
    push = bus.in_valid && bus.in_ready && !bus.flush;
    pop = bus.out_valid && bus.out_ready && !bus.flush;
    wr_ptr_d = bus.flush ? '0 : wr_ptr_q + PTR_W'(push);
    rd_ptr_d = bus.flush ? '0 : rd_ptr_q + PTR_W'(pop);
    count_d = bus.flush ? '0 : count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    instr_d = instr_q;
    pc4_d = pc4_q;
    if (push) begin
      instr_d[wr_ptr_q] = bus.in_instr;
      pc4_d[wr_ptr_q] = bus.in_pc4;
    end
    // empty queue presents an all-zero head, i.e. a MIPS NOP
    head = bus.out_valid ? instr_q[rd_ptr_q] : '0;
    bus.out_instr = head;
    bus.out_pc4 = bus.out_valid ? pc4_q[rd_ptr_q] : '0;
    bus.out_opcode = head[31:26];
    bus.out_rs = head[25:21];
    bus.out_rt = head[20:16];
    bus.out_rd = head[15:11];
    bus.out_shamt = head[10:6];
    bus.out_funct = head[5:0];
    bus.out_imm_sext = {{16{head[15]}}, head[15:0]};
    bus.out_jtarget = head[25:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc4_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      instr_q <= instr_d;
      pc4_q <= pc4_d;
    end
  end
endmodule
